wb_arbiter: RTL

//  Two-master, one-slave Wishbone (classic, B4) arbiter sharing main_memory.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_watchdog.sv | 43 ++++
 rtl/wb_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : shared Wishbone bus widths and arbiter ownership encoding
// Rev 1.0
// ============================================================================
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  function automatic logic [1:0] grant_of(input arb_state_e s);
    case (s)
      ARB_OWN0: return 2'b01;
      ARB_OWN1: return 2'b10;
      default:  return 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// wb_watchdog : counts stalled strobe cycles, fires for one cycle at LIMIT
// Rev 1.0
// ============================================================================
module wb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic fire
);

  localparam int              CNT_W   = $clog2(LIMIT) + 1;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign fire = (cnt_q == LIMIT_C);

  // Clearing on fire keeps the count from ever passing LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || fire) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// wb_arbiter : two-master / one-slave Wishbone B4 round-robin arbiter
// Rev 1.0
// ============================================================================
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int ADDR_W         = WB_ADDR_W,
  parameter int DATA_W         = WB_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W-1:0]   m0_dat_w,
  input  logic [DATA_W/8-1:0] m0_sel,
  output logic [DATA_W-1:0]   m0_dat_r,
  output logic                m0_ack,
  output logic                m0_err,
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W-1:0]   m1_dat_w,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic [DATA_W-1:0]   m1_dat_r,
  output logic                m1_ack,
  output logic                m1_err,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W-1:0]   s_dat_w,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic [DATA_W-1:0]   s_dat_r,
  input  logic                s_ack,
  input  logic                s_err,
  output logic [1:0]          grant,
  output logic                timeout
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       own0, own1;
  logic       wd_run, wd_clr, wd_fire;

  // last_q holds the master that most recently released the bus; the other wins a tie.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_cyc && m1_cyc) state_d = last_q ? ARB_OWN0 : ARB_OWN1;
        else if (m0_cyc)      state_d = ARB_OWN0;
        else if (m1_cyc)      state_d = ARB_OWN1;
      end
      ARB_OWN0: begin
        if (!m0_cyc) begin
          last_d  = 1'b0;
          state_d = m1_cyc ? ARB_OWN1 : ARB_IDLE;
        end
      end
      ARB_OWN1: begin
        if (!m1_cyc) begin
          last_d  = 1'b1;
          state_d = m0_cyc ? ARB_OWN0 : ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign own0 = (state_q == ARB_OWN0);
  assign own1 = (state_q == ARB_OWN1);

  // A watchdog expiry withdraws the strobe so the slave sees the cycle abandoned.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    if (own0) begin
      s_cyc   = m0_cyc;
      s_stb   = m0_stb && !wd_fire;
      s_we    = m0_we;
      s_adr   = m0_adr;
      s_dat_w = m0_dat_w;
      s_sel   = m0_sel;
    end else if (own1) begin
      s_cyc   = m1_cyc;
      s_stb   = m1_stb && !wd_fire;
      s_we    = m1_we;
      s_adr   = m1_adr;
      s_dat_w = m1_dat_w;
      s_sel   = m1_sel;
    end
  end

  assign m0_ack   = own0 && s_stb && s_ack;
  assign m1_ack   = own1 && s_stb && s_ack;
  assign m0_err   = own0 && ((s_stb && s_err) || wd_fire);
  assign m1_err   = own1 && ((s_stb && s_err) || wd_fire);
  assign m0_dat_r = own0 ? s_dat_r : '0;
  assign m1_dat_r = own1 ? s_dat_r : '0;

  assign grant   = grant_of(state_q);
  assign timeout = wd_fire;

  assign wd_run = s_cyc && s_stb && !s_ack && !s_err;
  assign wd_clr = (state_d != state_q) || s_ack || s_err || !s_stb;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      wb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
      ) u_wd (
        .clk   (clk),
        .reset (reset),
        .run   (wd_run),
        .clr   (wd_clr),
        .fire  (wd_fire)
      );
    end else begin : g_no_wd
      logic unused_wd;
      assign unused_wd = wd_run ^ wd_clr;
      assign wd_fire   = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire
